xif_issue_responder: RTL and testbench

- Parametrised testbench-side coprocessor model on the CV32E40X eXtension interface (XIF).
- Sits in the core testbench wrapper alongside mm_ram and replaces the passive issue-signal reader.
- Decodes issued instructions, accepts a configurable custom opcode, and tracks up to DEPTH in-flight offloads through commit/kill.
- Returns results in issue order after a programmable latency, with result backpressure.

---
 rtl/xif_resp_pkg.sv | 31 +++
 rtl/xif_resp_alu.sv | 46 ++++
 rtl/xif_issue_responder.sv | 166 ++++++++++++++++
 tb/tb_xif_issue_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_resp_pkg.sv
// Shared types for the XIF issue/commit/result responder model.
// Entry widths bound the supported ID and result widths.
package xif_resp_pkg;

  localparam int ENT_ID_W   = 4;
  localparam int ENT_DATA_W = 32;
  localparam int LAT_W      = 4;

  typedef enum logic [2:0] {
    FREE      = 3'd0,
    ISSUED    = 3'd1,
    COMMITTED = 3'd2,
    DONE      = 3'd3,
    KILLED    = 3'd4
  } entry_state_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUB = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b010;
  localparam logic [2:0] F3_AND = 3'b011;

  typedef struct packed {
    logic [ENT_ID_W-1:0]   id;
    logic [4:0]            rd;
    logic                  we;
    logic [ENT_DATA_W-1:0] data;
    logic [LAT_W-1:0]      lat_cnt;
    entry_state_e          state;
  } entry_t;

endpackage

// File: rtl/xif_resp_alu.sv
// Combinational decode and ALU for offloaded custom instructions.
// Only rs1 and rs2 take part; any rs3 is ignored.
module xif_resp_alu
  import xif_resp_pkg::*;
#(
  parameter int         X_NUM_RS    = 2,
  parameter int         X_RFR_WIDTH = 32,
  parameter int         X_RFW_WIDTH = 32,
  parameter logic [6:0] OPCODE      = 7'h0B
) (
  input  logic [31:0]                      instr,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0]  rs,
  output logic                             accept,
  output logic                             writeback,
  output logic [4:0]                       rd,
  output logic [X_RFW_WIDTH-1:0]           data
);

  logic [2:0]             f3;
  logic [X_RFW_WIDTH-1:0] a;
  logic [X_RFW_WIDTH-1:0] b;
  logic                   unused_bits;

  assign f3 = instr[14:12];
  assign rd = instr[11:7];
  assign a  = X_RFW_WIDTH'(rs[X_RFR_WIDTH-1:0]);
  assign b  = X_RFW_WIDTH'(rs[2*X_RFR_WIDTH-1:X_RFR_WIDTH]);

  // funct3 000..011 are exactly the four supported ops
  assign accept    = (instr[6:0] == OPCODE) && !f3[2];
  assign writeback = accept && (rd != 5'd0);

  always_comb begin
    data = '0;
    unique case (1'b1)
      f3 == F3_ADD: data = a + b;
      f3 == F3_SUB: data = a - b;
      f3 == F3_XOR: data = a ^ b;
      f3 == F3_AND: data = a & b;
      default:      data = '0;
    endcase
  end

  assign unused_bits = ^{instr[31:15], rs};

endmodule

// File: rtl/xif_issue_responder.sv
// XIF coprocessor model: in-order buffer tracking offloads through
// commit/kill and returning results after a fixed latency.
module xif_issue_responder
  import xif_resp_pkg::*;
#(
  parameter int         X_NUM_RS       = 2,
  parameter int         X_RFR_WIDTH    = 32,
  parameter int         X_RFW_WIDTH    = ENT_DATA_W,
  parameter int         X_ID_WIDTH     = ENT_ID_W,
  parameter int         DEPTH          = 4,
  parameter int         RESULT_LATENCY = 2,
  parameter logic [6:0] OPCODE         = 7'h0B
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [31:0]                     issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]           issue_id_i,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs_i,
  input  logic [X_NUM_RS-1:0]             issue_rs_valid_i,
  output logic                            issue_accept_o,
  output logic                            issue_writeback_o,
  input  logic                            commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]           commit_id_i,
  input  logic                            commit_kill_i,
  output logic                            result_valid_o,
  input  logic                            result_ready_i,
  output logic [X_ID_WIDTH-1:0]           result_id_o,
  output logic [X_RFW_WIDTH-1:0]          result_data_o,
  output logic [4:0]                      result_rd_o,
  output logic                            result_we_o,
  output logic [$clog2(DEPTH):0]          inflight_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [LAT_W-1:0] LAT = LAT_W'(RESULT_LATENCY);

  entry_t                 ent [DEPTH];
  entry_t                 hd;
  entry_t                 new_ent;
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [CW-1:0]          count;
  logic                   accept;
  logic                   writeback;
  logic [4:0]             rd;
  logic [X_RFW_WIDTH-1:0] alu_data;
  logic                   alloc;
  logic                   pop;
  logic                   same_cmt;
  entry_state_e           cmt_state;
  logic [DEPTH-1:0]       cmt_hit;
  logic [DEPTH-1:0]       dup_hit;
  logic [DEPTH-1:0]       bad_kill;

  xif_resp_alu #(
    .X_NUM_RS    (X_NUM_RS),
    .X_RFR_WIDTH (X_RFR_WIDTH),
    .X_RFW_WIDTH (X_RFW_WIDTH),
    .OPCODE      (OPCODE)
  ) u_alu (
    .instr     (issue_instr_i),
    .rs        (issue_rs_i),
    .accept    (accept),
    .writeback (writeback),
    .rd        (rd),
    .data      (alu_data)
  );

  assign hd = ent[head];

  assign issue_accept_o    = accept;
  assign issue_writeback_o = writeback;
  assign issue_ready_o     = !rst_i
                           && (count < CW'(DEPTH) || !accept)
                           && (&issue_rs_valid_i);

  assign alloc = issue_valid_i && issue_ready_o && accept;
  // killed head drains silently, one per cycle
  assign pop   = (hd.state == DONE && result_ready_i)
              || (hd.state == KILLED);

  assign cmt_state = commit_kill_i ? KILLED
                   : (RESULT_LATENCY == 0) ? DONE : COMMITTED;
  assign same_cmt  = commit_valid_i && (commit_id_i == issue_id_i);

  always_comb begin
    new_ent         = '0;
    new_ent.id      = ENT_ID_W'(issue_id_i);
    new_ent.rd      = rd;
    new_ent.we      = writeback;
    new_ent.data    = ENT_DATA_W'(alu_data);
    new_ent.lat_cnt = LAT;
    new_ent.state   = same_cmt ? cmt_state : ISSUED;
  end

  always_comb begin
    cmt_hit  = '0;
    dup_hit  = '0;
    bad_kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmt_hit[i]  = commit_valid_i && ent[i].state == ISSUED
                 && ent[i].id == ENT_ID_W'(commit_id_i);
      dup_hit[i]  = ent[i].state != FREE
                 && ent[i].id == ENT_ID_W'(issue_id_i);
      bad_kill[i] = commit_valid_i && commit_kill_i
                 && ent[i].state == COMMITTED
                 && ent[i].id == ENT_ID_W'(commit_id_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        unique case (ent[i].state)
          ISSUED: begin
            if (cmt_hit[i]) begin
              ent[i].state   <= cmt_state;
              ent[i].lat_cnt <= LAT;
            end
          end
          COMMITTED: begin
            ent[i].lat_cnt <= ent[i].lat_cnt - 1'b1;
            if (ent[i].lat_cnt == LAT_W'(1)) ent[i].state <= DONE;
          end
          default: ;
        endcase
      end
      if (pop) begin
        ent[head].state <= FREE;
        head            <= head + PW'(1);
      end
      if (alloc) begin
        ent[tail] <= new_ent;
        tail      <= tail + PW'(1);
      end
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  assign result_valid_o = !rst_i && hd.state == DONE;
  assign result_id_o    = result_valid_o ? X_ID_WIDTH'(hd.id) : '0;
  assign result_data_o  = result_valid_o ? X_RFW_WIDTH'(hd.data) : '0;
  assign result_rd_o    = result_valid_o ? hd.rd : 5'd0;
  assign result_we_o    = result_valid_o && hd.we;
  assign inflight_o     = count;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(alloc && |dup_hit))
        else $error("issue of in-flight id %0d", issue_id_i);
      assert (!(|bad_kill))
        else $error("kill of committed id %0d", commit_id_i);
      assert (count <= CW'(DEPTH))
        else $error("inflight count %0d above depth", count);
    end
  end

endmodule

// File: tb/tb_xif_issue_responder.sv
// Directed bench for xif_issue_responder with hand-computed results.
// Default parameters: DEPTH=4, RESULT_LATENCY=2, OPCODE=7'h0B.
module tb_xif_issue_responder;

  localparam logic [6:0] OPC = 7'h0B;
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] XOR = 3'b010;
  localparam logic [2:0] AND = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [63:0] issue_rs;
  logic [1:0]  issue_rs_valid;
  logic        issue_accept;
  logic        issue_writeback;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;
  logic [2:0]  inflight;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xif_issue_responder dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready),
    .issue_instr_i     (issue_instr),
    .issue_id_i        (issue_id),
    .issue_rs_i        (issue_rs),
    .issue_rs_valid_i  (issue_rs_valid),
    .issue_accept_o    (issue_accept),
    .issue_writeback_o (issue_writeback),
    .commit_valid_i    (commit_valid),
    .commit_id_i       (commit_id),
    .commit_kill_i     (commit_kill),
    .result_valid_o    (result_valid),
    .result_ready_i    (result_ready),
    .result_id_o       (result_id),
    .result_data_o     (result_data),
    .result_rd_o       (result_rd),
    .result_we_o       (result_we),
    .inflight_o        (inflight)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [6:0] op,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1;
    issue_id    = id;
    issue_instr = {7'd0, 5'd0, 5'd0, f3, rd, op};
    issue_rs    = {b, a};
    #1;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    issue_valid    = 1'b0;
    issue_instr    = '0;
    issue_id       = '0;
    issue_rs       = '0;
    issue_rs_valid = 2'b11;
    commit_valid   = 1'b0;
    commit_id      = '0;
    commit_kill    = 1'b0;
    result_ready   = 1'b0;
    step();
    step();
    check("rst_inflight", 32'(inflight), 0);
    check("rst_ready", 32'(issue_ready), 0);
    check("rst_rvalid", 32'(result_valid), 0);
    check("rst_we", 32'(result_we), 0);
    check("rst_data", result_data, 0);
    rst = 1'b0;
    #1;

    // ADD 5+7, commit one cycle later
    issue(3, OPC, ADD, 10, 5, 7);
    check("add_accept", 32'(issue_accept), 1);
    check("add_wb", 32'(issue_writeback), 1);
    check("add_ready", 32'(issue_ready), 1);
    step();
    idle();
    commit(3, 1'b0);
    check("add_inflight", 32'(inflight), 1);
    step();
    idle();
    check("add_lat1", 32'(result_valid), 0);
    step();
    check("add_lat2", 32'(result_valid), 0);
    step();
    check("add_rvalid", 32'(result_valid), 1);
    check("add_data", result_data, 12);
    check("add_rd", 32'(result_rd), 10);
    check("add_we", 32'(result_we), 1);
    check("add_id", 32'(result_id), 3);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    #1;
    check("add_popped", 32'(result_valid), 0);
    check("add_empty", 32'(inflight), 0);

    // SUB 0-1 with rd=0
    result_ready = 1'b1;
    issue(1, OPC, SUB, 0, 0, 1);
    check("sub_accept", 32'(issue_accept), 1);
    check("sub_wb", 32'(issue_writeback), 0);
    step();
    idle();
    commit(1, 1'b0);
    step();
    idle();
    step();
    step();
    check("sub_rvalid", 32'(result_valid), 1);
    check("sub_data", result_data, 32'hFFFF_FFFF);
    check("sub_we", 32'(result_we), 0);
    step();
    check("sub_empty", 32'(inflight), 0);
    result_ready = 1'b0;

    // foreign opcode
    issue(2, 7'h33, ADD, 5, 1, 1);
    check("rej_accept", 32'(issue_accept), 0);
    check("rej_ready", 32'(issue_ready), 1);
    step();
    idle();
    check("rej_inflight", 32'(inflight), 0);

    // fill all four entries
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), OPC, ADD, 1, 32'(i), 0);
      step();
    end
    idle();
    check("full_inflight", 32'(inflight), 4);
    issue(4, OPC, ADD, 1, 1, 1);
    check("full_acc_ready", 32'(issue_ready), 0);
    issue(5, 7'h33, ADD, 1, 1, 1);
    check("full_rej_ready", 32'(issue_ready), 1);
    step();
    idle();
    check("full_keep", 32'(inflight), 4);
    issue_rs_valid = 2'b01;
    issue(5, 7'h33, ADD, 1, 1, 1);
    check("rs_invalid_ready", 32'(issue_ready), 0);
    issue_rs_valid = 2'b11;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("full_cleared", 32'(inflight), 0);

    // kill 0, commit 2 then 1, stall result
    issue(0, OPC, ADD, 1, 1, 1);
    step();
    issue(1, OPC, XOR, 2, 32'h0000_F0F0, 32'h0000_0FF0);
    step();
    issue(2, OPC, AND, 3, 32'hFF00_FF00, 32'h0FF0_0FF0);
    step();
    idle();
    commit(0, 1'b1);
    check("ko_inflight3", 32'(inflight), 3);
    step();
    idle();
    commit(2, 1'b0);
    check("ko_kill_silent", 32'(result_valid), 0);
    step();
    idle();
    commit(1, 1'b0);
    check("ko_inflight2", 32'(inflight), 2);
    step();
    idle();
    check("ko_wait6", 32'(result_valid), 0);
    step();
    check("ko_wait7", 32'(result_valid), 0);
    step();
    for (int k = 0; k < 3; k++) begin
      check("ko_stall_valid", 32'(result_valid), 1);
      check("ko_stall_id", 32'(result_id), 1);
      check("ko_stall_data", result_data, 32'h0000_FF00);
      check("ko_stall_rd", 32'(result_rd), 2);
      step();
    end
    result_ready = 1'b1;
    #1;
    check("ko_first_id", 32'(result_id), 1);
    step();
    check("ko_second_valid", 32'(result_valid), 1);
    check("ko_second_id", 32'(result_id), 2);
    check("ko_second_data", result_data, 32'h0F00_0F00);
    check("ko_second_rd", 32'(result_rd), 3);
    step();
    check("ko_drained", 32'(result_valid), 0);
    check("ko_empty", 32'(inflight), 0);
    result_ready = 1'b0;

    // reset with a DONE entry pending
    issue(5, OPC, ADD, 4, 2, 3);
    step();
    issue(6, OPC, ADD, 4, 2, 3);
    step();
    issue(7, OPC, ADD, 4, 2, 3);
    commit(5, 1'b0);
    step();
    idle();
    step();
    step();
    check("mr_done_valid", 32'(result_valid), 1);
    check("mr_done_data", result_data, 5);
    check("mr_inflight3", 32'(inflight), 3);
    rst = 1'b1;
    #1;
    check("mr_forced_valid", 32'(result_valid), 0);
    check("mr_forced_ready", 32'(issue_ready), 0);
    step();
    rst = 1'b0;
    #1;
    check("mr_inflight", 32'(inflight), 0);
    check("mr_valid", 32'(result_valid), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("mr_no_stale", 32'(result_valid), 0);
    end

    // issue and commit of the same id in one cycle
    result_ready = 1'b1;
    issue(9, OPC, ADD, 7, 100, 23);
    commit(9, 1'b0);
    step();
    idle();
    step();
    step();
    check("sc_valid", 32'(result_valid), 1);
    check("sc_id", 32'(result_id), 9);
    check("sc_data", result_data, 123);
    step();
    check("sc_empty", 32'(inflight), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
